// File: rtl/mmio_router.sv
// Memory-mapped I/O router: decodes addr[31:20] against per-slave region tags and
// runs a registered request/ack transaction with per-slave wait states.
module mmio_router #(
  parameter int unsigned                N_SLAVES      = 4,
  parameter logic [12*N_SLAVES-1:0]     SLAVE_BASE    = {12'h008, 12'h003, 12'h002, 12'h001},
  parameter logic [4*N_SLAVES-1:0]      SLAVE_WAIT    = {4'd1, 4'd2, 4'd0, 4'd0},
  parameter int unsigned                DEFAULT_SLAVE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     we,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ack,
  output logic                     busy,
  output logic [N_SLAVES-1:0]      slv_sel,
  output logic                     slv_we,
  output logic [31:0]              slv_addr,
  output logic [31:0]              slv_wdata,
  input  logic [32*N_SLAVES-1:0]   slv_rdata,
  output logic [N_SLAVES-1:0]      slv_rd_pulse
);

  localparam int IDXW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [IDXW-1:0]      idx_q;
  logic                 we_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic                 ack_q;
  logic                 busy_q;
  logic [N_SLAVES-1:0]  sel_q;
  logic                 slv_we_q;
  logic [N_SLAVES-1:0]  rd_pulse_q;

  logic [N_SLAVES-1:0]  tag_hit;
  logic [31:0]          rdata_arr [N_SLAVES];
  logic [3:0]           wait_arr  [N_SLAVES];
  logic [IDXW-1:0]      idx_d;
  logic [N_SLAVES-1:0]  sel_d;
  logic [3:0]           cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi = gi + 1) begin : g_slv
      assign tag_hit[gi]   = (addr[31:20] == SLAVE_BASE[12*gi +: 12]);
      assign wait_arr[gi]  = SLAVE_WAIT[4*gi +: 4];
      assign rdata_arr[gi] = slv_rdata[32*gi +: 32];
      assign sel_d[gi]     = (idx_d == IDXW'(gi));
    end
  endgenerate

  // Scan from the top down so the lowest matching index overwrites last and wins.
  always_comb begin
    idx_d = IDXW'(DEFAULT_SLAVE);
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (tag_hit[i]) idx_d = IDXW'(i);
    end
  end

  assign cnt_d = wait_arr[idx_d];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      sel_q      <= '0;
      slv_we_q   <= 1'b0;
      rd_pulse_q <= '0;
    end else begin
      ack_q      <= 1'b0;
      rd_pulse_q <= '0;
      case (state_q)
        IDLE, DONE: begin
          if (req) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            we_q       <= we;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            slv_we_q   <= we;
            busy_q     <= 1'b1;
            rd_pulse_q <= we ? '0 : sel_d;
            state_q    <= ACCESS;
          end else begin
            state_q    <= IDLE;
          end
        end
        ACCESS: begin
          // Writes sit through the full wait count too; only reads update rdata.
          if (cnt_q == 4'd0) begin
            if (!we_q) rdata_q <= rdata_arr[idx_q];
            ack_q    <= 1'b1;
            busy_q   <= 1'b0;
            sel_q    <= '0;
            slv_we_q <= 1'b0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          sel_q    <= '0;
          slv_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdata        = rdata_q;
  assign ack          = ack_q;
  assign busy         = busy_q;
  assign slv_sel      = sel_q;
  assign slv_we       = slv_we_q;
  assign slv_addr     = addr_q;
  assign slv_wdata    = wdata_q;
  assign slv_rd_pulse = rd_pulse_q;

endmodule

// File: tb/tb_mmio_router.sv
// Self-checking bench for mmio_router: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a reference model.
module tb_mmio_router;

  logic         clk;
  logic         rst;
  logic         req;
  logic         we;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         ack;
  logic         busy;
  logic [3:0]   slv_sel;
  logic         slv_we;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_rd_pulse;

  mmio_router dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ack          (ack),
    .busy         (busy),
    .slv_sel      (slv_sel),
    .slv_we       (slv_we),
    .slv_addr     (slv_addr),
    .slv_wdata    (slv_wdata),
    .slv_rdata    (slv_rdata),
    .slv_rd_pulse (slv_rd_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory map as written down in the design description.
  localparam logic [11:0] TAGS [4] = '{12'h001, 12'h002, 12'h003, 12'h008};
  localparam int          WAITS [4] = '{0, 0, 2, 1};

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn    = 0;
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] slave_val   = 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rd_val;
    int          exp_idx;
    int          exp_w;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int model_idx(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if (a[31:20] == TAGS[i]) return i;
    return 0;
  endfunction

  // Selected slave sees v; the others see distinct values so a wrong mux is visible.
  task automatic set_slaves(input int sel, input logic [31:0] v);
    slave_val = v;
    for (int i = 0; i < 4; i++)
      slv_rdata[32*i +: 32] = (i == sel) ? v : (~v ^ (32'h0101_0101 * (i + 1)));
  endtask

  task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input int ei, input int ew);
    logic [31:0] exp_rd;
    logic [3:0]  oh;
    oh = '0;
    oh[ei] = 1'b1;
    exp_rd = w ? model_rdata : slave_val;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; wdata = wd;
    @(negedge clk);
    req = 1'b0; addr = $urandom; we = 1'($urandom); wdata = $urandom;
    for (int c = 0; c <= ew; c++) begin
      chk("acc_sel", 32'(slv_sel), 32'(oh));
      chk("acc_busy", 32'(busy), 32'd1);
      chk("acc_ack", 32'(ack), 32'd0);
      chk("acc_slv_we", 32'(slv_we), 32'(w));
      chk("acc_slv_addr", slv_addr, a);
      chk("acc_slv_wdata", slv_wdata, wd);
      chk("acc_rd_pulse", 32'(slv_rd_pulse), (c == 0 && !w) ? 32'(oh) : 32'd0);
      @(negedge clk);
    end
    chk("done_ack", 32'(ack), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_sel", 32'(slv_sel), 32'd0);
    chk("done_slv_we", 32'(slv_we), 32'd0);
    chk("done_rd_pulse", 32'(slv_rd_pulse), 32'd0);
    chk("done_rdata", rdata, exp_rd);
    model_rdata = exp_rd;
    n_txn++;
    $display("txn %0d addr=%h we=%b slave=%0d wait=%0d rdata=%h", n_txn, a, w, ei, ew, rdata);
  endtask

  initial begin
    int acks;
    logic [31:0] a;
    logic        w;
    int          idx;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; slv_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(slv_sel), 32'd0);
    chk("rst_slv_we", 32'(slv_we), 32'd0);
    chk("rst_rd_pulse", 32'(slv_rd_pulse), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_slv_addr", slv_addr, 32'd0);
    chk("rst_slv_wdata", slv_wdata, 32'd0);
    rst = 1'b0;

    vecs[0] = '{32'h0010_0040, 1'b0, 32'h0,         32'hDEAD_BEEF, 0, 0};
    vecs[1] = '{32'h0030_0000, 1'b0, 32'h0,         32'h5151_2222, 2, 2};
    vecs[2] = '{32'h0030_0000, 1'b1, 32'h7777_0001, 32'h0BAD_0002, 2, 2};
    vecs[3] = '{32'h0020_0010, 1'b1, 32'h0000_0041, 32'h0BAD_0003, 1, 0};
    vecs[4] = '{32'h0090_0000, 1'b0, 32'h0,         32'h9090_0004, 0, 0};
    vecs[5] = '{32'h0080_1234, 1'b0, 32'h0,         32'h8080_0005, 3, 1};
    vecs[6] = '{32'h000F_FFFF, 1'b0, 32'h0,         32'h0F0F_0006, 0, 0};
    for (int v = 0; v < 7; v++) begin
      set_slaves(vecs[v].exp_idx, vecs[v].rd_val);
      run_txn(vecs[v].addr, vecs[v].we, vecs[v].wdata, vecs[v].exp_idx, vecs[v].exp_w);
    end

    // req held high: three back-to-back reads to slave 3, ack every third cycle.
    set_slaves(3, 32'hCAFE_0003);
    @(negedge clk);
    req = 1'b1; addr = 32'h0080_0100; we = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      chk("b2b_ack", 32'(ack), 32'(n % 3 == 0 && n <= 9));
      chk("b2b_busy", 32'(busy), 32'(n % 3 != 0 && n <= 8));
      chk("b2b_rd_pulse", 32'(slv_rd_pulse), (n == 1 || n == 4 || n == 7) ? 32'h8 : 32'h0);
      if (n % 3 == 0 && n <= 9) chk("b2b_rdata", rdata, 32'hCAFE_0003);
      if (n == 7) req = 1'b0;
    end
    model_rdata = 32'hCAFE_0003;
    $display("b2b sequence: three reads to slave 3 with req held high");

    // A req pulse during ACCESS must be dropped, not queued.
    set_slaves(2, 32'h0BAD_F00D);
    @(negedge clk);
    req = 1'b1; addr = 32'h0030_0004; we = 1'b0;
    acks = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (ack) acks++;
      chk("ign_ack", 32'(ack), 32'(n == 4));
      chk("ign_busy", 32'(busy), 32'(n <= 3));
      chk("ign_sel", 32'(slv_sel), (n <= 3) ? 32'h4 : 32'h0);
      if (n == 4) chk("ign_rdata", rdata, 32'h0BAD_F00D);
      if (n == 1) req = 1'b0;
      if (n == 2) begin req = 1'b1; addr = 32'h0010_0000; end
      if (n == 3) req = 1'b0;
    end
    chk("ign_ack_count", 32'(acks), 32'd1);
    model_rdata = 32'h0BAD_F00D;
    $display("ignore sequence: req during ACCESS dropped");

    // Reset in the middle of a W=2 read clears everything at once.
    set_slaves(2, 32'h1234_5678);
    @(negedge clk);
    req = 1'b1; addr = 32'h0030_0000; we = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(slv_sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_rd_pulse", 32'(slv_rd_pulse), 32'd0);
    chk("mid_rst_slv_we", 32'(slv_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("post_rst_no_ack", 32'(acks), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    model_rdata = 32'h0;
    $display("reset sequence: transaction dropped");
    set_slaves(2, 32'h4242_0002);
    run_txn(32'h0030_0008, 1'b0, 32'h0, 2, 2);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      int k;
      k = $urandom_range(0, 4);
      a = {(k < 4) ? TAGS[k] : 12'($urandom), 20'($urandom)};
      w = 1'($urandom);
      idx = model_idx(a);
      set_slaves(idx, $urandom);
      run_txn(a, w, $urandom, idx, WAITS[idx]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
